// File: rtl/uart_rx_mmr.sv
// uart_rx_mmr: 16x-oversampled 8N1 UART receiver with a receive FIFO.
// The core reads status and data through a two-word memory-mapped window.
module uart_rx_mmr #(
   parameter logic [31:0] BASE       = 32'h0000_0200,
   parameter int unsigned DIVISOR    = 14,
   parameter int unsigned DEPTH_LOG2 = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        rw,
   input  logic [31:0] addr,
   inout  wire  [31:0] data,
   input  logic        rxd,
   output logic        irq
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   localparam int unsigned       DIV_W     = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIVISOR - 1);
   localparam int unsigned       DEPTH     = 1 << DEPTH_LOG2;
   localparam int unsigned       PTR_W     = DEPTH_LOG2 + 1;
   localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
   localparam logic [31:0]       DATA_ADDR = BASE + 32'd1;

   // synchronizer
   logic sync1_q, sync2_q;
   logic rxd_s;

   // baud divider
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick;

   // receiver
   state_t     state_q, state_d;
   logic [3:0] samp_q, samp_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic       push;
   logic       frame_err;

   // FIFO and flags
   logic [7:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic             empty, full;
   logic             push_ok, pop, ovr_set;
   logic             ovr_q, ovr_d, ferr_q, ferr_d;

   // bus decode
   logic        rd_sel_stat, rd_sel_data, wr_sel_stat;
   logic [31:0] rdata;
   logic        unused_data;

   assign rxd_s = sync2_q;

   // Two-flop synchronizer on the asynchronous serial line, idle-high preset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rxd;
         sync2_q <= sync1_q;
      end
   end

   // Free-running divider: one tick per 1/16 bit time.
   always_comb begin
      tick  = (div_q == DIV_LAST);
      div_d = tick ? '0 : div_q + DIV_W'(1);
   end

   // Divider register.
   always_ff @(posedge clk) begin
      if (reset) div_q <= '0;
      else       div_q <= div_d;
   end

   // Receiver state register and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         samp_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         samp_q  <= samp_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   // Receiver next-state: start detect, mid-start check, 8 data samples, stop check.
   always_comb begin
      state_d   = state_q;
      samp_d    = samp_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      push      = 1'b0;
      frame_err = 1'b0;
      if (tick) begin
         case (state_q)
            S_IDLE: begin
               if (!rxd_s) begin
                  state_d = S_START;
                  samp_d  = '0;
               end
            end
            S_START: begin
               if (samp_q == 4'd7) begin
                  if (!rxd_s) begin
                     state_d = S_DATA;
                     samp_d  = '0;
                     bit_d   = '0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  samp_d = samp_q + 4'd1;
               end
            end
            S_DATA: begin
               if (samp_q == 4'd15) begin
                  shift_d = {rxd_s, shift_q[7:1]};
                  samp_d  = '0;
                  if (bit_q == 3'd7) state_d = S_STOP;
                  else               bit_d   = bit_q + 3'd1;
               end else begin
                  samp_d = samp_q + 4'd1;
               end
            end
            S_STOP: begin
               if (samp_q == 4'd15) begin
                  samp_d  = '0;
                  state_d = S_IDLE;
                  if (rxd_s) push      = 1'b1;
                  else       frame_err = 1'b1;
               end else begin
                  samp_d = samp_q + 4'd1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Bus decode, FIFO pointer and sticky-flag next-state, read mux.
   always_comb begin
      rd_sel_stat = enable & ~rw & (addr == BASE);
      rd_sel_data = enable & ~rw & (addr == DATA_ADDR);
      wr_sel_stat = enable &  rw & (addr == BASE);

      empty = (wr_q == rd_q);
      full  = (wr_q[DEPTH_LOG2] != rd_q[DEPTH_LOG2]) &&
              (wr_q[DEPTH_LOG2-1:0] == rd_q[DEPTH_LOG2-1:0]);

      // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
      pop     = rd_sel_data & ~empty;
      push_ok = push & (~full | pop);
      ovr_set = push & full & ~pop;

      wr_d = push_ok ? wr_q + PTR_ONE : wr_q;
      rd_d = pop     ? rd_q + PTR_ONE : rd_q;

      // Set wins over a software clear in the same cycle.
      ovr_d  = ovr_set   | (ovr_q  & ~(wr_sel_stat & data[1]));
      ferr_d = frame_err | (ferr_q & ~(wr_sel_stat & data[2]));

      rdata = '0;
      if (rd_sel_stat) begin
         rdata = {28'b0, full, ferr_q, ovr_q, ~empty};
      end else if (rd_sel_data && !empty) begin
         rdata = {24'b0, mem_q[rd_q[DEPTH_LOG2-1:0]]};
      end
   end

   // FIFO pointers and sticky error flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q   <= '0;
         rd_q   <= '0;
         ovr_q  <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         ovr_q  <= ovr_d;
         ferr_q <= ferr_d;
      end
   end

   // FIFO storage; contents are qualified by the pointers, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q[DEPTH_LOG2-1:0]] <= shift_q;
   end

   assign data        = (rd_sel_stat | rd_sel_data) ? rdata : 'z;
   assign irq         = ~empty;
   assign unused_data = ^{data[31:3], data[0]};

endmodule

// File: tb/tb_uart_rx_mmr.sv
// tb_uart_rx_mmr: directed bench for the memory-mapped UART receiver.
module tb_uart_rx_mmr;

   localparam logic [31:0] BASE    = 32'h0000_0200;
   localparam int unsigned DIV     = 14;
   localparam int unsigned BIT_CYC = 16 * DIV;

   logic        clk = 1'b0;
   logic        reset, enable, rw, rxd;
   logic [31:0] addr;
   logic [31:0] drv;
   logic        drv_en;
   wire  [31:0] data;
   wire         irq;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned cyc   = 0;
   int unsigned rst_e = 0;

   assign data = drv_en ? drv : 'z;

   uart_rx_mmr #(
      .BASE       (BASE),
      .DIVISOR    (DIV),
      .DEPTH_LOG2 (3)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .rw     (rw),
      .addr   (addr),
      .data   (data),
      .rxd    (rxd),
      .irq    (irq)
   );

   always #5 clk = ~clk;

   // Edge counter; remembers the last edge seen with reset high so the
   // divider phase (ticks every DIV edges after it) can be predicted.
   always @(posedge clk) begin
      if (reset) rst_e <= cyc;
      cyc <= cyc + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
      @(negedge clk);
      enable = 1'b1;
      rw     = 1'b0;
      addr   = a;
      #1 v = data;
      @(negedge clk);
      enable = 1'b0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      enable = 1'b1;
      rw     = 1'b1;
      addr   = a;
      drv    = d;
      drv_en = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      rw     = 1'b0;
      drv_en = 1'b0;
   endtask

   // Sends one frame. A bad stop bit is held low just past its mid-sample and
   // then released. With pop_at_stop set, a data read is issued on exactly the
   // edge where the stop bit is sampled.
   task automatic send_byte(input logic [7:0] b, input logic stop_ok,
                            input logic pop_at_stop, output logic [31:0] popped);
      int unsigned e0, t0, p, guard;
      popped = '0;
      @(negedge clk);
      rxd = 1'b0;
      e0  = cyc;
      t0  = e0 + 2;
      while (((t0 - rst_e) % DIV) != 0) t0++;
      p = t0 + DIV * 152;
      repeat (BIT_CYC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (BIT_CYC) @(negedge clk);
      end
      rxd = stop_ok;
      if (!stop_ok) begin
         repeat (154) @(negedge clk);
         rxd = 1'b1;
         repeat (BIT_CYC - 154) @(negedge clk);
      end else if (pop_at_stop) begin
         guard = 0;
         while (cyc < p && guard < 300) begin
            @(negedge clk);
            guard++;
         end
         chk("stop_align", {31'b0, (cyc == p)}, 32'd1);
         enable = 1'b1;
         rw     = 1'b0;
         addr   = BASE + 32'd1;
         #1 popped = data;
         @(negedge clk);
         enable = 1'b0;
         while (cyc < e0 + 10 * BIT_CYC) @(negedge clk);
      end else begin
         repeat (BIT_CYC) @(negedge clk);
      end
   endtask

   initial begin
      logic [31:0] v;
      rxd    = 1'b1;
      enable = 1'b0;
      rw     = 1'b0;
      addr   = '0;
      drv    = '0;
      drv_en = 1'b0;
      reset  = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // reset state
      bus_read(BASE, v);
      chk("rst_status", v, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      bus_read(BASE + 32'd1, v);
      chk("rst_empty_read", v, 32'h0);

      // single byte A5
      send_byte(8'hA5, 1'b1, 1'b0, v);
      chk("a5_irq", {31'b0, irq}, 32'h1);
      bus_read(BASE, v);
      chk("a5_status", v, 32'h1);
      bus_write(BASE + 32'd1, 32'hFFFF_FFFF);
      bus_read(BASE, v);
      chk("a5_wr_data_ignored", v, 32'h1);
      bus_read(BASE + 32'd1, v);
      chk("a5_data", v, 32'hA5);
      bus_read(BASE, v);
      chk("a5_status_after", v, 32'h0);
      chk("a5_irq_after", {31'b0, irq}, 32'h0);

      // short low glitch is rejected
      @(negedge clk);
      rxd = 1'b0;
      repeat (5 * DIV) @(negedge clk);
      rxd = 1'b1;
      repeat (400) @(negedge clk);
      bus_read(BASE, v);
      chk("glitch_status", v, 32'h0);
      chk("glitch_irq", {31'b0, irq}, 32'h0);

      // framing error on 3C
      send_byte(8'h3C, 1'b0, 1'b0, v);
      repeat (300) @(negedge clk);
      bus_read(BASE, v);
      chk("ferr_status", v, 32'h4);
      chk("ferr_irq", {31'b0, irq}, 32'h0);
      bus_write(BASE, 32'h4);
      bus_read(BASE, v);
      chk("ferr_cleared", v, 32'h0);

      // overrun: nine bytes into an eight-deep FIFO
      for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1, 1'b0, v);
      bus_read(BASE, v);
      chk("ovr_status", v, 32'hB);
      for (int i = 1; i <= 8; i++) begin
         bus_read(BASE + 32'd1, v);
         chk($sformatf("ovr_data%0d", i), v, 32'(i));
      end
      bus_read(BASE + 32'd1, v);
      chk("ovr_empty_read", v, 32'h0);
      bus_read(BASE, v);
      chk("ovr_status_drained", v, 32'h2);
      bus_write(BASE, 32'h2);
      bus_read(BASE, v);
      chk("ovr_cleared", v, 32'h0);

      // push into full FIFO with simultaneous pop
      for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), 1'b1, 1'b0, v);
      bus_read(BASE, v);
      chk("full_status", v, 32'h9);
      send_byte(8'h55, 1'b1, 1'b1, v);
      chk("pushpop_head", v, 32'h10);
      bus_read(BASE, v);
      chk("pushpop_status", v, 32'h9);
      for (int i = 1; i < 8; i++) begin
         bus_read(BASE + 32'd1, v);
         chk($sformatf("pushpop_data%0d", i), v, 32'(8'h10 + i));
      end
      bus_read(BASE + 32'd1, v);
      chk("pushpop_last", v, 32'h55);
      bus_read(BASE, v);
      chk("pushpop_drained", v, 32'h0);

      // reset during data bit 4 of 7E abandons the frame
      @(negedge clk);
      rxd = 1'b0;
      repeat (BIT_CYC) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rxd = (i == 0) ? 1'b0 : 1'b1;
         repeat (BIT_CYC) @(negedge clk);
      end
      rxd = 1'b1;
      repeat (100) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (10 * BIT_CYC) @(negedge clk);
      bus_read(BASE, v);
      chk("midrst_status", v, 32'h0);
      chk("midrst_irq", {31'b0, irq}, 32'h0);
      send_byte(8'h7E, 1'b1, 1'b0, v);
      bus_read(BASE, v);
      chk("resync_status", v, 32'h1);
      bus_read(BASE + 32'd1, v);
      chk("resync_data", v, 32'h7E);
      bus_read(BASE, v);
      chk("resync_drained", v, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
